pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Sequences the ECP5 EHXPLLL clock generator: pulses PLL RST, waits for a stable LOCK, then releases downstream
//  clock-domain resets in a fixed order. On lock loss it re-asserts all domain resets and re-runs bring-up.
//  Runs on the 25 MHz board reference clock, which stays alive when the PLL drops. Sits between the PLL wrapper and SoC resets.
// PARAMETERS
//  RST_PULSE_CYCLES    16      cycles PLL RST is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES  4096    consecutive synced-lock cycles required before release (>=1)
//  LOCK_TIMEOUT_CYCLES 250000  max cycles in WAIT_LOCK+STABLE per attempt (10 ms @25 MHz)
//  NUM_DOMAINS         4       number of downstream domain resets (1..8)
//  RELEASE_GAP_CYCLES  16      cycles between successive domain releases (>=1)
//  MAX_ATTEMPTS        8       failed attempts before FAULT (1..15)
// PORTS
//  clkin_25MHz      in   1            reference clock, all logic on this edge
//  resetn           in   1            asynchronous, active-low reset
//  pll_locked       in   1            PLL LOCK, asynchronous to clkin_25MHz
//  force_relock     in   1            1-cycle pulse: restart full bring-up from any state
//  pll_rst          out  1            to PLL RST, active-high
//  domain_rst_n     out  NUM_DOMAINS  per-domain reset, active-low; consumers resync deassertion locally
//  ready            out  1            all domains released, PLL locked
//  fault            out  1            MAX_ATTEMPTS exhausted
//  attempt_count    out  4            failed attempts since last RUN
//  lock_loss_count  out  8            lock drops seen in RUN, saturating at 255
// BEHAVIOUR
//  Reset values: pll_rst=1, domain_rst_n=0, ready=0, fault=0, attempt_count=0, lock_loss_count=0, state=PRST.
//  All outputs are registered. pll_locked passes through a 2-FF synchronizer -> lock_s, 2 cycles of latency.
//  States:
//   PRST    pll_rst=1 for RST_PULSE_CYCLES, then WAIT. Timeout counter is cleared on entry.
//   WAIT    pll_rst=0. lock_s=1 -> STABLE. Timeout counter expires -> attempt_count+1.
//           If the new count == MAX_ATTEMPTS -> FAULT; otherwise -> PRST.
//   STABLE  Counts consecutive cycles with lock_s=1. lock_s=0 -> WAIT; the stable count clears, the timeout keeps running.
//           Count reaches LOCK_STABLE_CYCLES -> REL with idx=0. Timeout expiry is handled as in WAIT.
//   REL     Deasserts domain_rst_n[idx], then waits RELEASE_GAP_CYCLES before idx+1. Lower index is released first.
//           After idx=NUM_DOMAINS-1 -> RUN. lock_s=0 -> LOSS.
//   RUN     ready=1, attempt_count cleared on entry. lock_s=0 -> LOSS.
//   LOSS    One cycle: all domain_rst_n=0, ready=0, lock_loss_count+1 (saturating), -> PRST. No attempt charged.
//   FAULT   pll_rst=1, all domain_rst_n=0, fault=1. Leaves only via force_relock or resetn.
//  Domain-reset assertion timing is a hard requirement:
//   - From LOSS: domain_rst_n goes low on the clock edge that enters LOSS.
//   - Overall: within 3 cycles of pll_locked falling.
//  force_relock, any state: next edge -> PRST, with all domain_rst_n=0, ready=0, fault=0, attempt_count=0.
//   It has priority over every other transition in the same cycle.
//  Simultaneous lock drop and timeout expiry in STABLE: the timeout wins and the attempt is charged.
//  resetn low mid-operation: all outputs go asynchronously to reset values. pll_rst=1 immediately.
//  Counters: one shared down-counter, width $clog2(max of cycle params)+1, plus a separate timeout counter.
//  Widths must not truncate at the default parameters.
// STRUCTURE
//  pll_sup_pkg: state encoding localparams (PRST,WAIT,STABLE,REL,RUN,LOSS,FAULT) and the counter-width function.
//  The TB includes it to decode state.
//  Sub-module sync_2ff (1-bit, async active-low reset to 0) for pll_locked; reusable for other CDC inputs.
// TESTING  (bench params: RST_PULSE=4, STABLE=8, TIMEOUT=32, NUM_DOMAINS=3, GAP=2, MAX_ATTEMPTS=2)
//  1 resetn rises; pll_locked rises 5 cycles after pll_rst falls
//    -> pll_rst high exactly 4 cycles; domains 0,1,2 release 2 cycles apart; ready=1; attempt_count=0.
//  2 Lock drops for 1 cycle after 5 STABLE cycles
//    -> stable count restarts; ready is delayed by the extra cycles; no attempt charged.
//  3 pll_locked held 0
//    -> two 4-cycle pll_rst pulses with 32-cycle gaps; then fault=1, pll_rst=1, attempt_count=2, domains held.
//  4 Lock drop in RUN
//    -> all domain_rst_n=0 within 3 cycles; lock_loss_count=1; 4-cycle pll_rst pulse; full re-release sequence.
//  5 force_relock while domain 1 is releasing
//    -> next edge: all domain_rst_n=0, pll_rst=1; sequence restarts. force_relock in FAULT clears fault.
//  6 resetn low during RUN
//    -> all outputs at reset values before the next clock edge; lock_loss_count=0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding,
// output field widths and the counter-width helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PRST   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        REL    = 3'd3,
        RUN    = 3'd4,
        LOSS   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam int ATTEMPT_W  = 4;
    localparam int LOSS_CNT_W = 8;

    // Extra bit keeps the largest loaded value representable when it is a power of two.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Output resets to 0 and follows the input after two destination clock edges.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // NOTE: clocked state uses non-blocking assignments so both flops sample the old values on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and ordered release of downstream domain
// resets; re-runs bring-up on lock loss and gives up after repeated lock timeouts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 4096,
    parameter int LOCK_TIMEOUT_CYCLES = 250000,
    parameter int NUM_DOMAINS         = 4,
    parameter int RELEASE_GAP_CYCLES  = 16,
    parameter int MAX_ATTEMPTS        = 8
) (
    input  logic                   clkin_25MHz,
    input  logic                   resetn,
    input  logic                   pll_locked,
    input  logic                   force_relock,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fault,
    output logic [ATTEMPT_W-1:0]   attempt_count,
    output logic [LOSS_CNT_W-1:0]  lock_loss_count
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, RELEASE_GAP_CYCLES);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES, 1, 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]     RST_LOAD    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     GAP_LOAD    = CNT_W'(RELEASE_GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [ATTEMPT_W-1:0] ATTEMPT_MAX = ATTEMPT_W'(MAX_ATTEMPTS);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [TMO_W-1:0]        r_tmo;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_pll_rst;
    logic [NUM_DOMAINS-1:0]  r_dom;
    logic                    r_ready;
    logic                    r_fault;
    logic [ATTEMPT_W-1:0]    r_attempt;
    logic [LOSS_CNT_W-1:0]   r_loss_cnt;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [TMO_W-1:0]        w_tmo_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [NUM_DOMAINS-1:0]  w_dom_nxt;
    logic [ATTEMPT_W-1:0]    w_attempt_nxt;
    logic [LOSS_CNT_W-1:0]   w_loss_nxt;
    logic                    w_lock_s;
    logic                    w_tmo_expired;
    logic [ATTEMPT_W-1:0]    w_attempt_inc;
    logic [IDX_W-1:0]        w_idx_inc;

    sync_2ff u_lock_sync (
        .clk   (clkin_25MHz),
        .rst_n (resetn),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    assign w_tmo_expired = (r_tmo == TMO_LAST);
    assign w_attempt_inc = r_attempt + 1'b1;
    assign w_idx_inc     = r_idx + 1'b1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tmo_nxt     = r_tmo;
        w_idx_nxt     = r_idx;
        w_dom_nxt     = r_dom;
        w_attempt_nxt = r_attempt;
        w_loss_nxt    = r_loss_cnt;

        case (r_state)
            PRST: begin
                w_dom_nxt = '0;
                w_tmo_nxt = '0;
                if (r_cnt == '0) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            WAIT, STABLE: begin
                w_tmo_nxt = r_tmo + 1'b1;
                // Timeout outranks both lock arrival and a same-cycle lock drop.
                if (w_tmo_expired) begin
                    w_attempt_nxt = w_attempt_inc;
                    w_tmo_nxt     = '0;
                    if (w_attempt_inc == ATTEMPT_MAX) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_state_nxt = PRST;
                        w_cnt_nxt   = RST_LOAD;
                    end
                end else if (r_state == WAIT) begin
                    if (w_lock_s) begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = STABLE_LOAD;
                    end
                end else if (!w_lock_s) begin
                    w_state_nxt = WAIT;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = REL;
                    w_idx_nxt    = '0;
                    w_dom_nxt[0] = 1'b1;
                    w_cnt_nxt    = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            REL, RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = LOSS;
                    w_dom_nxt   = '0;
                    if (r_loss_cnt != '1) begin
                        w_loss_nxt = r_loss_cnt + 1'b1;
                    end
                end else if (r_state == REL) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (r_idx == IDX_LAST) begin
                        w_state_nxt   = RUN;
                        w_attempt_nxt = '0;
                    end else begin
                        w_idx_nxt            = w_idx_inc;
                        w_dom_nxt[w_idx_inc] = 1'b1;
                        w_cnt_nxt            = GAP_LOAD;
                    end
                end
            end

            LOSS: begin
                w_state_nxt = PRST;
                w_cnt_nxt   = RST_LOAD;
                w_tmo_nxt   = '0;
                w_dom_nxt   = '0;
            end

            FAULT: begin
                w_dom_nxt = '0;
            end

            default: begin
                w_state_nxt = PRST;
                w_cnt_nxt   = RST_LOAD;
                w_tmo_nxt   = '0;
                w_dom_nxt   = '0;
            end
        endcase

        if (force_relock) begin
            w_state_nxt   = PRST;
            w_cnt_nxt     = RST_LOAD;
            w_tmo_nxt     = '0;
            w_dom_nxt     = '0;
            w_attempt_nxt = '0;
        end
    end

    always_ff @(posedge clkin_25MHz or negedge resetn) begin
        if (!resetn) begin
            r_state    <= PRST;
            r_cnt      <= RST_LOAD;
            r_tmo      <= '0;
            r_idx      <= '0;
            r_pll_rst  <= 1'b1;
            r_dom      <= '0;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
            r_attempt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tmo      <= w_tmo_nxt;
            r_idx      <= w_idx_nxt;
            r_pll_rst  <= (w_state_nxt == PRST) || (w_state_nxt == FAULT);
            r_dom      <= w_dom_nxt;
            r_ready    <= (w_state_nxt == RUN);
            r_fault    <= (w_state_nxt == FAULT);
            r_attempt  <= w_attempt_nxt;
            r_loss_cnt <= w_loss_nxt;
        end
    end

    assign pll_rst         = r_pll_rst;
    assign domain_rst_n    = r_dom;
    assign ready           = r_ready;
    assign fault           = r_fault;
    assign attempt_count   = r_attempt;
    assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small cycle parameters; each task
// drives one scenario and compares outputs against hand-derived cycle counts.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int RP  = 4;
    localparam int ST  = 8;
    localparam int TO  = 32;
    localparam int ND  = 3;
    localparam int GAP = 2;
    localparam int MA  = 2;

    localparam int SEL_PLLRST = 0;
    localparam int SEL_DOM0   = 1;
    localparam int SEL_DOM1   = 2;
    localparam int SEL_DOM2   = 3;
    localparam int SEL_READY  = 4;
    localparam int SEL_FAULT  = 5;

    logic          clk          = 1'b0;
    logic          resetn       = 1'b0;
    logic          pll_locked   = 1'b0;
    logic          force_relock = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] domain_rst_n;
    logic          ready;
    logic          fault;
    logic [3:0]    attempt_count;
    logic [7:0]    lock_loss_count;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_STABLE_CYCLES  (ST),
        .LOCK_TIMEOUT_CYCLES (TO),
        .NUM_DOMAINS         (ND),
        .RELEASE_GAP_CYCLES  (GAP),
        .MAX_ATTEMPTS        (MA)
    ) dut (
        .clkin_25MHz     (clk),
        .resetn          (resetn),
        .pll_locked      (pll_locked),
        .force_relock    (force_relock),
        .pll_rst         (pll_rst),
        .domain_rst_n    (domain_rst_n),
        .ready           (ready),
        .fault           (fault),
        .attempt_count   (attempt_count),
        .lock_loss_count (lock_loss_count)
    );

    always #20 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic sig(input int sel);
        case (sel)
            SEL_PLLRST: sig = pll_rst;
            SEL_DOM0:   sig = domain_rst_n[0];
            SEL_DOM1:   sig = domain_rst_n[1];
            SEL_DOM2:   sig = domain_rst_n[2];
            SEL_READY:  sig = ready;
            default:    sig = fault;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of rising edges until the selected output equals val, or -1.
    task automatic wait_for(input int sel, input logic val, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (sig(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        resetn       = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        n_checks++; if (domain_rst_n !== 3'b000) begin n_fail++; $display("FAIL reset_dom: got %b want 000", domain_rst_n); end
        n_checks++; if (ready !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ready %b fault %b want 0 0", ready, fault); end
        n_checks++; if (attempt_count !== 4'd0 || lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_counts: attempt %0d loss %0d want 0 0", attempt_count, lock_loss_count); end
        n_checks++; if (dut.r_state !== PRST) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, PRST); end
    endtask

    task automatic test_bringup();
        int n;
        resetn = 1'b1;
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        n_checks++; if (n !== RP) begin n_fail++; $display("FAIL bringup_prst_len: got %0d want %0d", n, RP); end
        repeat (5) step();
        pll_locked = 1'b1;
        wait_for(SEL_DOM0, 1'b1, 40, n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL bringup_dom0_delay: got %0d want 11", n); end
        n_checks++; if (domain_rst_n !== 3'b001) begin n_fail++; $display("FAIL bringup_dom0_only: got %b want 001", domain_rst_n); end
        wait_for(SEL_DOM1, 1'b1, 10, n);
        n_checks++; if (n !== GAP || domain_rst_n !== 3'b011) begin n_fail++; $display("FAIL bringup_dom1: gap %0d dom %b want %0d 011", n, domain_rst_n, GAP); end
        wait_for(SEL_DOM2, 1'b1, 10, n);
        n_checks++; if (n !== GAP || domain_rst_n !== 3'b111) begin n_fail++; $display("FAIL bringup_dom2: gap %0d dom %b want %0d 111", n, domain_rst_n, GAP); end
        wait_for(SEL_READY, 1'b1, 10, n);
        n_checks++; if (n !== GAP) begin n_fail++; $display("FAIL bringup_ready_delay: got %0d want %0d", n, GAP); end
        n_checks++; if (attempt_count !== 4'd0 || pll_rst !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL bringup_run_outputs: attempt %0d pll_rst %b fault %b want 0 0 0", attempt_count, pll_rst, fault); end
    endtask

    task automatic test_stable_glitch();
        int n;
        apply_reset();
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        n_checks++; if (n !== RP) begin n_fail++; $display("FAIL glitch_prst_len: got %0d want %0d", n, RP); end
        pll_locked = 1'b1;
        repeat (6) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_for(SEL_DOM0, 1'b1, 40, n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL glitch_dom0_delay: got %0d want 11", n); end
        wait_for(SEL_READY, 1'b1, 20, n);
        n_checks++; if (n !== 3 * GAP) begin n_fail++; $display("FAIL glitch_ready_delay: got %0d want %0d", n, 3 * GAP); end
        n_checks++; if (attempt_count !== 4'd0) begin n_fail++; $display("FAIL glitch_no_attempt: got %0d want 0", attempt_count); end
    endtask

    task automatic test_timeout_fault();
        int n;
        apply_reset();
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        n_checks++; if (n !== RP) begin n_fail++; $display("FAIL tmo_prst1_len: got %0d want %0d", n, RP); end
        wait_for(SEL_PLLRST, 1'b1, 60, n);
        n_checks++; if (n !== TO) begin n_fail++; $display("FAIL tmo_wait1_len: got %0d want %0d", n, TO); end
        n_checks++; if (attempt_count !== 4'd1 || domain_rst_n !== 3'b000) begin n_fail++; $display("FAIL tmo_attempt1: attempt %0d dom %b want 1 000", attempt_count, domain_rst_n); end
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        n_checks++; if (n !== RP) begin n_fail++; $display("FAIL tmo_prst2_len: got %0d want %0d", n, RP); end
        wait_for(SEL_FAULT, 1'b1, 60, n);
        n_checks++; if (n !== TO) begin n_fail++; $display("FAIL tmo_fault_delay: got %0d want %0d", n, TO); end
        n_checks++; if (pll_rst !== 1'b1 || attempt_count !== 4'(MA)) begin n_fail++; $display("FAIL tmo_fault_outputs: pll_rst %b attempt %0d want 1 %0d", pll_rst, attempt_count, MA); end
        n_checks++; if (dut.r_state !== FAULT) begin n_fail++; $display("FAIL tmo_fault_state: got %0d want %0d", dut.r_state, FAULT); end
        pll_locked = 1'b1;
        repeat (20) step();
        n_checks++; if (fault !== 1'b1 || domain_rst_n !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL tmo_fault_sticky: fault %b dom %b ready %b want 1 000 0", fault, domain_rst_n, ready); end
    endtask

    task automatic test_lock_loss();
        int n;
        apply_reset();
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        pll_locked = 1'b1;
        wait_for(SEL_READY, 1'b1, 60, n);
        n_checks++; if (n !== 17) begin n_fail++; $display("FAIL loss_bringup: got %0d want 17", n); end
        pll_locked = 1'b0;
        wait_for(SEL_DOM0, 1'b0, 10, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL loss_dom_assert_delay: got %0d want 3", n); end
        n_checks++; if (domain_rst_n !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL loss_dom_all: dom %b ready %b want 000 0", domain_rst_n, ready); end
        n_checks++; if (lock_loss_count !== 8'd1 || attempt_count !== 4'd0) begin n_fail++; $display("FAIL loss_counts: loss %0d attempt %0d want 1 0", lock_loss_count, attempt_count); end
        wait_for(SEL_PLLRST, 1'b1, 5, n);
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL loss_prst_entry: got %0d want 1", n); end
        pll_locked = 1'b1;
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        n_checks++; if (n !== RP) begin n_fail++; $display("FAIL loss_prst_len: got %0d want %0d", n, RP); end
        wait_for(SEL_DOM0, 1'b1, 30, n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL loss_redom0: got %0d want 9", n); end
        wait_for(SEL_DOM1, 1'b1, 10, n);
        n_checks++; if (n !== GAP) begin n_fail++; $display("FAIL loss_redom1: got %0d want %0d", n, GAP); end
        wait_for(SEL_DOM2, 1'b1, 10, n);
        n_checks++; if (n !== GAP) begin n_fail++; $display("FAIL loss_redom2: got %0d want %0d", n, GAP); end
        wait_for(SEL_READY, 1'b1, 10, n);
        n_checks++; if (n !== GAP || lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL loss_reready: delay %0d loss %0d want %0d 1", n, lock_loss_count, GAP); end
    endtask

    task automatic test_force_relock();
        int n;
        apply_reset();
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        pll_locked = 1'b1;
        wait_for(SEL_DOM1, 1'b1, 40, n);
        n_checks++; if (n !== 13 || domain_rst_n !== 3'b011) begin n_fail++; $display("FAIL force_pre_dom1: delay %0d dom %b want 13 011", n, domain_rst_n); end
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        n_checks++; if (domain_rst_n !== 3'b000 || pll_rst !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL force_next_edge: dom %b pll_rst %b ready %b want 000 1 0", domain_rst_n, pll_rst, ready); end
        n_checks++; if (dut.r_state !== PRST) begin n_fail++; $display("FAIL force_state: got %0d want %0d", dut.r_state, PRST); end
        wait_for(SEL_PLLRST, 1'b0, 20, n);
        n_checks++; if (n !== RP) begin n_fail++; $display("FAIL force_prst_len: got %0d want %0d", n, RP); end
        wait_for(SEL_READY, 1'b1, 40, n);
        n_checks++; if (n !== 15 || domain_rst_n !== 3'b111) begin n_fail++; $display("FAIL force_reready: delay %0d dom %b want 15 111", n, domain_rst_n); end
        pll_locked = 1'b0;
        wait_for(SEL_FAULT, 1'b1, 200, n);
        n_checks++; if (n !== 76) begin n_fail++; $display("FAIL force_fault_delay: got %0d want 76", n); end
        n_checks++; if (lock_loss_count !== 8'd1 || attempt_count !== 4'd2) begin n_fail++; $display("FAIL force_fault_counts: loss %0d attempt %0d want 1 2", lock_loss_count, attempt_count); end
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        n_checks++; if (fault !== 1'b0 || pll_rst !== 1'b1 || attempt_count !== 4'd0 || domain_rst_n !== 3'b000) begin n_fail++; $display("FAIL force_clear_fault: fault %b pll_rst %b attempt %0d dom %b want 0 1 0 000", fault, pll_rst, attempt_count, domain_rst_n); end
        pll_locked = 1'b1;
        wait_for(SEL_READY, 1'b1, 40, n);
        n_checks++; if (n !== 19) begin n_fail++; $display("FAIL force_recover: got %0d want 19", n); end
    endtask

    task automatic test_reset_in_run();
        n_checks++; if (ready !== 1'b1 || lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL rstrun_pre: ready %b loss %0d want 1 1", ready, lock_loss_count); end
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        n_checks++; if (pll_rst !== 1'b1 || domain_rst_n !== 3'b000 || ready !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL rstrun_async_outputs: pll_rst %b dom %b ready %b fault %b want 1 000 0 0", pll_rst, domain_rst_n, ready, fault); end
        n_checks++; if (lock_loss_count !== 8'd0 || attempt_count !== 4'd0) begin n_fail++; $display("FAIL rstrun_counts: loss %0d attempt %0d want 0 0", lock_loss_count, attempt_count); end
        step();
        n_checks++; if (dut.r_state !== PRST) begin n_fail++; $display("FAIL rstrun_state: got %0d want %0d", dut.r_state, PRST); end
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_stable_glitch();
        test_timeout_fault();
        test_lock_loss();
        test_force_relock();
        test_reset_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
